spi_if: RTL and testbench

- Serial front end of the tiny processor.
- Load mode (driver_io_in=1): the external master streams 12-bit {addr,data} words over miso_in, one bit per clk. addr_out/data_out feed the icache/dcache write ports and the frame counter buffer.
- Exec mode (driver_io_in=0): acts as a mode-0 SPI master for the processor's send/read instructions. Transmits alu_res and captures a received byte into the SPI source register (data_out). Signals completion via ready_out so the control logic can release its stall.

---
 rtl/spi_if_pkg.sv | 17 +
 rtl/spi_sclk_gen.sv | 66 ++++++
 rtl/spi_if.sv | 121 ++++++++++++
 tb/tb_spi_if.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_if_pkg.sv
// Shared definitions for the serial front end: widths, sclk divider
// default and exec-mode FSM state encoding.
package spi_if_pkg;

    localparam int SPI_DATA_W   = 8;
    localparam int SPI_ADDR_W   = 4;
    localparam int SPI_WORD_W   = SPI_DATA_W + SPI_ADDR_W;
    localparam int SPI_SCLK_DIV = 2;

    typedef enum logic [1:0] {
        SPI_IDLE  = 2'b00,
        SPI_SETUP = 2'b01,
        SPI_XFER  = 2'b10,
        SPI_DONE  = 2'b11
    } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock generator: half-period and bit counters running while enabled,
// with strobes on the cycles that precede each sclk edge.
module spi_sclk_gen
    import spi_if_pkg::*;
#(
    parameter int SCLK_DIV = SPI_SCLK_DIV,
    parameter int NBITS    = SPI_DATA_W
) (
    input  logic clk,
    input  logic rst,
    input  logic en_in,
    output logic sclk_out,
    output logic rise_stb_out,
    output logic fall_stb_out,
    output logic last_bit_out
);

    localparam int HC_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [HC_W-1:0]  HC_MAX  = HC_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(NBITS - 1);

    logic [HC_W-1:0]  hc_q, hc_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             phase_q, phase_d;
    logic             half_end;

    assign half_end = (hc_q == HC_MAX);

    always_comb begin
        hc_d    = hc_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        if (!en_in) begin
            hc_d    = '0;
            bit_d   = '0;
            phase_d = 1'b0;
        end else if (half_end) begin
            hc_d    = '0;
            phase_d = ~phase_q;
            if (phase_q) begin
                bit_d = bit_q + BIT_W'(1);
            end
        end else begin
            hc_d = hc_q + HC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q    <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
        end
    end

    assign sclk_out     = phase_q;
    assign rise_stb_out = en_in && half_end && !phase_q;
    assign fall_stb_out = en_in && half_end && phase_q;
    assign last_bit_out = (bit_q == BIT_MAX);

endmodule

// File: rtl/spi_if.sv
// Serial front end: load-mode word shifter for cache fill, and a mode-0
// SPI master for the send/read instructions in exec mode.
module spi_if
    import spi_if_pkg::*;
#(
    parameter int DATA_W   = SPI_DATA_W,
    parameter int ADDR_W   = SPI_ADDR_W,
    parameter int SCLK_DIV = SPI_SCLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              driver_io_in,
    input  logic              read_in,
    input  logic              send_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              miso_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              ready_out,
    output logic              sclk_out,
    output logic              mosi_out,
    output logic              cs_out
);

    localparam int WORD_W = DATA_W + ADDR_W;

    spi_state_e        state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              is_send_q, is_send_d;

    logic gen_sclk;
    logic rise_stb;
    logic fall_stb;
    logic last_bit;
    logic req;
    logic active;

    assign req = send_in || read_in;

    spi_sclk_gen #(
        .SCLK_DIV (SCLK_DIV),
        .NBITS    (DATA_W)
    ) u_sclk_gen (
        .clk          (clk),
        .rst          (rst),
        .en_in        (state_q == SPI_XFER),
        .sclk_out     (gen_sclk),
        .rise_stb_out (rise_stb),
        .fall_stb_out (fall_stb),
        .last_bit_out (last_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SPI_IDLE;
            sreg_q    <= '0;
            tx_q      <= '0;
            is_send_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            tx_q      <= tx_d;
            is_send_q <= is_send_d;
        end
    end

    // Load mode overrides the exec FSM, which also aborts any transfer.
    always_comb begin
        state_d = state_q;
        if (driver_io_in) begin
            state_d = SPI_IDLE;
        end else begin
            unique case (state_q)
                SPI_IDLE:  if (req) state_d = SPI_SETUP;
                SPI_SETUP: state_d = SPI_XFER;
                SPI_XFER:  if (fall_stb && last_bit) state_d = SPI_DONE;
                SPI_DONE:  state_d = SPI_IDLE;
                default:   state_d = SPI_IDLE;
            endcase
        end
    end

    always_comb begin
        sreg_d    = sreg_q;
        tx_d      = tx_q;
        is_send_d = is_send_q;
        if (driver_io_in) begin
            if (read_in) begin
                sreg_d = {sreg_q[WORD_W-2:0], miso_in};
            end
        end else begin
            if (state_q == SPI_IDLE && req) begin
                is_send_d = send_in;
                if (send_in) begin
                    tx_d = data_in;
                end
            end
            if (state_q == SPI_XFER && fall_stb) begin
                tx_d = {tx_q[DATA_W-2:0], 1'b0};
            end
            // Receive keeps the address nibble intact.
            if (state_q == SPI_XFER && rise_stb && !is_send_q) begin
                sreg_d[DATA_W-1:0] = {sreg_q[DATA_W-2:0], miso_in};
            end
        end
    end

    always_comb begin
        active    = !driver_io_in &&
                    (state_q == SPI_SETUP || state_q == SPI_XFER);
        cs_out    = !active;
        sclk_out  = active && (state_q == SPI_XFER) && gen_sclk;
        mosi_out  = active && is_send_q && tx_q[DATA_W-1];
        ready_out = !driver_io_in && (state_q == SPI_DONE);
    end

    assign addr_out = sreg_q[WORD_W-1:DATA_W];
    assign data_out = sreg_q[DATA_W-1:0];

endmodule

// File: tb/tb_spi_if.sv
// Directed bench for spi_if: reset, load shifting, send/read transfers,
// back-to-back requests, abort by load mode and by reset.
module tb_spi_if;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       driver_io_in = 1'b0;
    logic       read_in = 1'b0;
    logic       send_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       miso_in = 1'b0;
    logic [3:0] addr_out;
    logic [7:0] data_out;
    logic       ready_out;
    logic       sclk_out;
    logic       mosi_out;
    logic       cs_out;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    always #5 clk = ~clk;

    spi_if dut (
        .clk          (clk),
        .rst          (rst),
        .driver_io_in (driver_io_in),
        .read_in      (read_in),
        .send_in      (send_in),
        .data_in      (data_in),
        .miso_in      (miso_in),
        .addr_out     (addr_out),
        .data_out     (data_out),
        .ready_out    (ready_out),
        .sclk_out     (sclk_out),
        .mosi_out     (mosi_out),
        .cs_out       (cs_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs ncyc cycles after the request edge; acts as the slave on miso.
    task automatic run_xfer(
        input  int         ncyc,
        input  int         drop_at,
        input  logic [7:0] slave,
        input  int         dchg_at,
        input  logic [7:0] dchg_val,
        output logic [15:0] mosi_bits,
        output int         rdy1,
        output int         rdy2,
        output int         rdy_cnt,
        output int         cs_low,
        output int         cs_bad_rdy,
        output logic [7:0] dout_rdy
    );
        logic prev_sclk;
        int   k;
        mosi_bits  = '0;
        rdy1       = -1;
        rdy2       = -1;
        rdy_cnt    = 0;
        cs_low     = 0;
        cs_bad_rdy = 0;
        dout_rdy   = 8'h00;
        prev_sclk  = 1'b0;
        k          = 7;
        miso_in    = slave[7];
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            tick();
            if (sclk_out && !prev_sclk)
                mosi_bits = {mosi_bits[14:0], mosi_out};
            if (!sclk_out && prev_sclk) begin
                k = (k == 0) ? 7 : k - 1;
                miso_in = slave[k];
            end
            prev_sclk = sclk_out;
            if (!cs_out) cs_low++;
            if (ready_out) begin
                rdy_cnt++;
                if (rdy_cnt == 1) rdy1 = cyc;
                else if (rdy_cnt == 2) rdy2 = cyc;
                if (!cs_out) cs_bad_rdy++;
                dout_rdy = data_out;
            end
            if (cyc == dchg_at) data_in = dchg_val;
            if (cyc == drop_at) begin
                send_in = 1'b0;
                read_in = 1'b0;
            end
        end
    endtask

    task automatic load_bits(input logic [15:0] w, input int n);
        driver_io_in = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            read_in = 1'b1;
            miso_in = w[i];
            tick();
        end
        read_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tot_cnt++;
        if (cs_out !== 1'b1) $display("FAIL rst_cs got %b want 1", cs_out);
        else pass_cnt++;
        tot_cnt++;
        if (sclk_out !== 1'b0) $display("FAIL rst_sclk got %b want 0", sclk_out);
        else pass_cnt++;
        tot_cnt++;
        if (mosi_out !== 1'b0) $display("FAIL rst_mosi got %b want 0", mosi_out);
        else pass_cnt++;
        tot_cnt++;
        if (ready_out !== 1'b0) $display("FAIL rst_ready got %b want 0", ready_out);
        else pass_cnt++;
        tot_cnt++;
        if (addr_out !== 4'h0) $display("FAIL rst_addr got %h want 0", addr_out);
        else pass_cnt++;
        tot_cnt++;
        if (data_out !== 8'h00) $display("FAIL rst_data got %h want 00", data_out);
        else pass_cnt++;
    endtask

    task automatic test_load();
        load_bits(16'h03A5, 12);
        tot_cnt++;
        if (addr_out !== 4'h3) $display("FAIL load_addr got %h want 3", addr_out);
        else pass_cnt++;
        tot_cnt++;
        if (data_out !== 8'hA5) $display("FAIL load_data got %h want a5", data_out);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            miso_in = i[0];
            tick();
            tot_cnt++;
            if ({addr_out, data_out} !== 12'h3A5)
                $display("FAIL load_hold%0d got %h want 3a5", i, {addr_out, data_out});
            else pass_cnt++;
        end
        load_bits(16'h0FFF, 12);
        load_bits(16'h33A5, 14);
        tot_cnt++;
        if ({addr_out, data_out} !== 12'h3A5)
            $display("FAIL load_14bit got %h want 3a5", {addr_out, data_out});
        else pass_cnt++;
        tot_cnt++;
        if (cs_out !== 1'b1 || ready_out !== 1'b0)
            $display("FAIL load_ctl got cs=%b rdy=%b want cs=1 rdy=0", cs_out, ready_out);
        else pass_cnt++;
    endtask

    task automatic test_send();
        logic [15:0] mb;
        logic [7:0]  want;
        logic [7:0]  dr;
        int r1, r2, rc, csl, csb;
        want = 8'hC3;
        driver_io_in = 1'b0;
        data_in = 8'hC3;
        send_in = 1'b1;
        run_xfer(40, 34, 8'h00, 0, 8'h00, mb, r1, r2, rc, csl, csb, dr);
        for (int i = 0; i < 8; i++) begin
            tot_cnt++;
            if (mb[7-i] !== want[7-i])
                $display("FAIL send_mosi_bit%0d got %b want %b", i, mb[7-i], want[7-i]);
            else pass_cnt++;
        end
        tot_cnt++;
        if (r1 !== 34) $display("FAIL send_ready_cyc got %0d want 34", r1);
        else pass_cnt++;
        tot_cnt++;
        if (rc !== 1) $display("FAIL send_ready_cnt got %0d want 1", rc);
        else pass_cnt++;
        tot_cnt++;
        if (csl !== 33) $display("FAIL send_cs_low got %0d want 33", csl);
        else pass_cnt++;
        tot_cnt++;
        if (csb !== 0) $display("FAIL send_cs_at_done got %0d want 0", csb);
        else pass_cnt++;
        tot_cnt++;
        if (data_out !== 8'hA5) $display("FAIL send_sreg got %h want a5", data_out);
        else pass_cnt++;
    endtask

    task automatic test_read();
        logic [15:0] mb;
        logic [7:0]  dr;
        int r1, r2, rc, csl, csb;
        driver_io_in = 1'b0;
        read_in = 1'b1;
        run_xfer(40, 34, 8'h5A, 0, 8'h00, mb, r1, r2, rc, csl, csb, dr);
        tot_cnt++;
        if (dr !== 8'h5A) $display("FAIL read_data got %h want 5a", dr);
        else pass_cnt++;
        tot_cnt++;
        if (rc !== 1 || r1 !== 34)
            $display("FAIL read_ready got cnt=%0d cyc=%0d want 1/34", rc, r1);
        else pass_cnt++;
        tot_cnt++;
        if (addr_out !== 4'h3) $display("FAIL read_addr got %h want 3", addr_out);
        else pass_cnt++;
        tot_cnt++;
        if (mb[7:0] !== 8'h00) $display("FAIL read_mosi got %h want 00", mb[7:0]);
        else pass_cnt++;
        tot_cnt++;
        if (csl !== 33) $display("FAIL read_cs_low got %0d want 33", csl);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] mb;
        logic [7:0]  dr;
        int r1, r2, rc, csl, csb;
        driver_io_in = 1'b0;
        data_in = 8'h01;
        send_in = 1'b1;
        run_xfer(75, 69, 8'h00, 10, 8'hFF, mb, r1, r2, rc, csl, csb, dr);
        tot_cnt++;
        if (mb !== 16'h01FF) $display("FAIL b2b_mosi got %h want 01ff", mb);
        else pass_cnt++;
        tot_cnt++;
        if (rc !== 2) $display("FAIL b2b_ready_cnt got %0d want 2", rc);
        else pass_cnt++;
        tot_cnt++;
        if (r1 !== 34) $display("FAIL b2b_ready1 got %0d want 34", r1);
        else pass_cnt++;
        tot_cnt++;
        if (r2 - r1 !== 35) $display("FAIL b2b_gap got %0d want 35", r2 - r1);
        else pass_cnt++;
        tot_cnt++;
        if (csl !== 66) $display("FAIL b2b_cs_low got %0d want 66", csl);
        else pass_cnt++;
        tot_cnt++;
        if (csb !== 0) $display("FAIL b2b_cs_at_done got %0d want 0", csb);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int rc;
        int csl;
        driver_io_in = 1'b0;
        data_in = 8'hC3;
        send_in = 1'b1;
        for (int c = 1; c <= 10; c++) tick();
        tot_cnt++;
        if (cs_out !== 1'b0) $display("FAIL abort_pre_cs got %b want 0", cs_out);
        else pass_cnt++;
        driver_io_in = 1'b1;
        send_in = 1'b0;
        read_in = 1'b1;
        miso_in = 1'b1;
        tick();
        read_in = 1'b0;
        tot_cnt++;
        if (cs_out !== 1'b1 || sclk_out !== 1'b0 || ready_out !== 1'b0)
            $display("FAIL abort_io got cs=%b sclk=%b rdy=%b want 1/0/0",
                     cs_out, sclk_out, ready_out);
        else pass_cnt++;
        tot_cnt++;
        if ({addr_out, data_out} !== 12'h6B5)
            $display("FAIL abort_shift got %h want 6b5", {addr_out, data_out});
        else pass_cnt++;
        rc = 0;
        csl = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ready_out) rc++;
            if (!cs_out) csl++;
        end
        tot_cnt++;
        if (rc !== 0 || csl !== 0)
            $display("FAIL abort_quiet got rdy=%0d csl=%0d want 0/0", rc, csl);
        else pass_cnt++;

        driver_io_in = 1'b0;
        send_in = 1'b1;
        for (int c = 1; c <= 10; c++) tick();
        tot_cnt++;
        if (cs_out !== 1'b0) $display("FAIL rstab_pre_cs got %b want 0", cs_out);
        else pass_cnt++;
        rst = 1'b1;
        send_in = 1'b0;
        tick();
        rst = 1'b0;
        tot_cnt++;
        if (cs_out !== 1'b1 || sclk_out !== 1'b0 ||
            mosi_out !== 1'b0 || ready_out !== 1'b0)
            $display("FAIL rstab_io got cs=%b sclk=%b mosi=%b rdy=%b want 1/0/0/0",
                     cs_out, sclk_out, mosi_out, ready_out);
        else pass_cnt++;
        tot_cnt++;
        if ({addr_out, data_out} !== 12'h000)
            $display("FAIL rstab_sreg got %h want 000", {addr_out, data_out});
        else pass_cnt++;
        rc = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ready_out) rc++;
        end
        tot_cnt++;
        if (rc !== 0) $display("FAIL rstab_ready got %0d want 0", rc);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_send();
        test_read();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
